serial_add_sched: RTL and testbench
===================================

SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

Interface
REQ-001: Parameter WIDTH SHALL be: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002: Port clk SHALL be: clk, input, 1, single clock; all state changes on the rising edge.
REQ-003: Port rst SHALL be: rst, input, 1, synchronous active-high reset.
REQ-004: Port req0 SHALL be: req0, input, 1, requester 0 add request (level).
REQ-005: Port a0 SHALL be: a0, input, WIDTH, requester 0 operand A.
REQ-006: Port b0 SHALL be: b0, input, WIDTH, requester 0 operand B.
REQ-007: Port req1 SHALL be: req1, input, 1, requester 1 add request (level).
REQ-008: Port a1 SHALL be: a1, input, WIDTH, requester 1 operand A.
REQ-009: Port b1 SHALL be: b1, input, WIDTH, requester 1 operand B.
REQ-010: Port gnt SHALL be: gnt, output, 1, index of the requester currently owning the adder.
REQ-011: Port busy SHALL be: busy, output, 1, high in the ADD and DONE states.
REQ-012: Port done0 SHALL be: done0, output, 1, one-cycle completion pulse to requester 0.
REQ-013: Port done1 SHALL be: done1, output, 1, one-cycle completion pulse to requester 1.
REQ-014: Port sum SHALL be: sum, output, WIDTH+1, result with carry-out in the MSB.

Function
REQ-015: The block SHALL share one bit-serial full-adder cell, built from two half adders (sum = XOR, carry = AND, carry-out = OR of the two carries), between the two requesters.
REQ-016: The FSM SHALL have three states: IDLE, ADD and DONE.
REQ-017: IDLE -> ADD SHALL occur at an edge where req0 or req1 is high; at that edge the block latches the winner into gnt, captures the winner's A and B into shift registers, and clears the bit counter and the carry.
REQ-018: Arbitration SHALL be round-robin: a lone request wins; when both are high, the requester not granted last time wins; the last-grant register resets to 1, so req0 wins the first tie.
REQ-019: In ADD, each edge SHALL process bit[cnt] LSB-first, shift the sum bit into the result register, update the carry, and increment cnt.
REQ-020: ADD -> DONE SHALL occur at the edge that processes cnt = WIDTH-1, so ADD lasts exactly WIDTH cycles.
REQ-021: At the ADD -> DONE edge, sum SHALL update to {carry, result}.
REQ-022: In DONE, done[gnt] SHALL be high for exactly one cycle; DONE -> IDLE always occurs on the next edge.
REQ-023: Latency from the grant edge to the done pulse SHALL be WIDTH+1 cycles; throughput SHALL be one operation per WIDTH+2 cycles.
REQ-024: sum SHALL hold its value until the next completion.
REQ-025: gnt SHALL hold its value while busy.
REQ-026: Requests arriving in ADD or DONE SHALL be ignored until IDLE; operand changes after the grant edge SHALL NOT affect the result.
REQ-027: A requester holding req high through its done pulse SHALL be treated as a new request in the following IDLE cycle, subject to round-robin.
REQ-028: Arithmetic SHALL be unsigned modulo 2^(WIDTH+1); overflow is reported only through sum[WIDTH].

Reset
REQ-029: On rst high at an edge: state = IDLE, gnt = 0, busy = 0, done0 = 0, done1 = 0, sum = 0, cnt = 0, carry = 0, last-grant = 1.
REQ-030: Reset SHALL take priority over every other event, including a request in the same cycle.
REQ-031: Reset asserted mid-ADD SHALL abort the operation with no done pulse.

Verification
REQ-032: Reset check: hold rst for 2 cycles with both req high -> all outputs 0, busy low, no grant taken during reset.
REQ-033: Single request (WIDTH=8): req0, a0=0xFF, b0=0x01 -> busy rises at the grant edge; done0 fires 9 cycles later; sum=0x100; done1 stays 0.
REQ-034: Data patterns: requester 1 with 0xAA+0x55 -> sum=0x0FF; 0x00+0x00 -> sum=0x000; 0x80+0x80 -> sum=0x100.
REQ-035: Tie: req0 and req1 high together right after reset -> requester 0 served first (gnt=0, done0); requester 1 granted at the next IDLE; done1 arrives 10 cycles after done0.
REQ-036: Abort: rst pulsed on the 4th ADD cycle -> no done pulse, sum=0; a fresh req1 with 0x03+0x04 then yields sum=0x007.
REQ-037: Fairness: both req held high for 6 operations -> gnt alternates 0,1,0,1,0,1; busy drops for exactly one cycle between operations.

Source files
------------

// File: rtl/serial_add_sched.sv
// Two-requester unsigned adder sharing one bit-serial full-adder cell.
// Round-robin arbitration, LSB-first addition over WIDTH cycles, one-cycle done pulse.
module serial_add_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt,
    output logic             busy,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH:0]   sum
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Returns {carry, sum} of a half adder.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    state_e           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;

    logic [1:0]       ha1_s;
    logic [1:0]       ha2_s;
    logic             bit_s;
    logic             cout_s;
    logic             win_s;

    // Shared full-adder cell and arbitration winner.
    always_comb begin
        ha1_s  = half_add(a_sh_q[0], b_sh_q[0]);
        ha2_s  = half_add(ha1_s[0], carry_q);
        bit_s  = ha2_s[0];
        cout_s = ha1_s[1] | ha2_s[1];
        // On a tie the requester not served last time wins.
        win_s  = (req0 && req1) ? ~last_q : req1;
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        sum_d   = sum_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        done0_d = 1'b0;
        done1_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_ADD;
                    gnt_d   = win_s;
                    last_d  = win_s;
                    a_sh_d  = win_s ? a1 : a0;
                    b_sh_d  = win_s ? b1 : b0;
                    res_d   = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    carry_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                a_sh_d         = a_sh_q >> 1;
                b_sh_d         = b_sh_q >> 1;
                // Each sum bit lands directly at its final bit position.
                res_d[cnt_q]   = bit_s;
                carry_d        = cout_s;
                cnt_d          = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = ST_DONE;
                    sum_d   = {cout_s, res_d};
                    done0_d = ~gnt_q;
                    done1_d = gnt_q;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            busy_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            sum_q   <= {(WIDTH+1){1'b0}};
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            sum_q   <= sum_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    assign gnt   = gnt_q;
    assign busy  = busy_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign sum   = sum_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Self-checking bench for serial_add_sched: directed tables, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_serial_add_sched;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst, req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             gnt, busy, done0, done1;
    logic [WIDTH:0]   sum;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an operation occupies the block for WIDTH+1 cycles after its grant.
    int               m_left;
    logic             m_gnt, m_last, m_done0, m_done1;
    logic [WIDTH-1:0] m_a, m_b;
    logic [WIDTH:0]   m_sum;

    typedef struct {
        logic             sel;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   exp;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    serial_add_sched #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt(gnt), .busy(busy), .done0(done0), .done1(done1), .sum(sum)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        logic c_rst, c_r0, c_r1, w;
        logic [WIDTH-1:0] c_a0, c_b0, c_a1, c_b1;
        c_rst = rst; c_r0 = req0; c_r1 = req1;
        c_a0 = a0; c_b0 = b0; c_a1 = a1; c_b1 = b1;
        @(posedge clk);
        #1;
        m_done0 = 1'b0;
        m_done1 = 1'b0;
        if (c_rst) begin
            m_left = 0; m_gnt = 1'b0; m_last = 1'b1; m_sum = '0;
        end else if (m_left == 0) begin
            if (c_r0 || c_r1) begin
                w      = (c_r0 && c_r1) ? !m_last : c_r1;
                m_gnt  = w;
                m_last = w;
                m_a    = w ? c_a1 : c_a0;
                m_b    = w ? c_b1 : c_b0;
                m_left = WIDTH + 1;
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                m_sum = {1'b0, m_a} + {1'b0, m_b};
                if (m_gnt) m_done1 = 1'b1;
                else       m_done0 = 1'b1;
            end
        end
        check("model_gnt",   32'(gnt),   32'(m_gnt));
        check("model_busy",  32'(busy),  32'(m_left > 0));
        check("model_done0", 32'(done0), 32'(m_done0));
        check("model_done1", 32'(done1), 32'(m_done1));
        check("model_sum",   32'(sum),   32'(m_sum));
    endtask

    // Lone request from one requester; checks latency, owner and result.
    task automatic run_vec(input vec_t v);
        int lat;
        bit got;
        req0 = !v.sel; req1 = v.sel;
        if (v.sel) begin a1 = v.a; b1 = v.b; end
        else       begin a0 = v.a; b0 = v.b; end
        step();
        check("vec_grant_gnt",  32'(gnt),  32'(v.sel));
        check("vec_grant_busy", 32'(busy), 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1;
        lat = 1; got = 1'b0;
        while (!got && lat < 4 * WIDTH) begin
            step();
            lat++;
            if (done0 || done1) got = 1'b1;
        end
        check("vec_done_seen", 32'(got), 32'd1);
        check("vec_latency",   32'(lat), 32'(WIDTH + 1));
        check("vec_done_own",  32'(v.sel ? done1 : done0), 32'd1);
        check("vec_done_other", 32'(v.sel ? done0 : done1), 32'd0);
        check("vec_sum",       32'(sum), 32'(v.exp));
        step();
        check("vec_done_cleared", 32'(done0 | done1), 32'd0);
        check("vec_sum_held",  32'(sum), 32'(v.exp));
    endtask

    initial begin
        int edge_n, n_done, n_gnt, idle_steps, prev_done_edge;
        bit prev_busy, spurious;
        logic gnts[6];

        vecs[0] = '{1'b1, 8'h03, 8'h04, 9'h007};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 9'h100};
        vecs[2] = '{1'b1, 8'hAA, 8'h55, 9'h0FF};
        vecs[3] = '{1'b1, 8'h00, 8'h00, 9'h000};
        vecs[4] = '{1'b1, 8'h80, 8'h80, 9'h100};
        vecs[5] = '{1'b0, 8'hFF, 8'hFF, 9'h1FE};

        m_left = 0; m_gnt = 1'b0; m_last = 1'b1; m_sum = '0;
        m_done0 = 1'b0; m_done1 = 1'b0; m_a = '0; m_b = '0;

        // Reset held with both requests high: no grant may be taken.
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        a0 = 8'h12; b0 = 8'h34; a1 = 8'h56; b1 = 8'h78;
        step();
        step();
        check("rst_gnt",  32'(gnt),  32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'({done0, done1}), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);

        // Tie right after reset, then sustained contention for six operations.
        rst = 1'b0;
        edge_n = 0; n_done = 0; n_gnt = 0; idle_steps = 0; prev_done_edge = 0;
        prev_busy = 1'b0;
        while (n_done < 6 && edge_n < 6 * (WIDTH + 2) + 20) begin
            step();
            edge_n++;
            if (busy && !prev_busy && n_gnt < 6) begin
                gnts[n_gnt] = gnt;
                n_gnt++;
            end
            if (!busy && n_gnt > 0) idle_steps++;
            if (done0 || done1) begin
                if (n_done == 0) check("tie_first_done0", 32'(done0), 32'd1);
                if (n_done == 0) check("tie_first_sum", 32'(sum), 32'h046);
                if (n_done == 1) check("tie_second_sum", 32'(sum), 32'h0CE);
                if (n_done > 0)  check("fair_done_spacing", 32'(edge_n - prev_done_edge), 32'(WIDTH + 2));
                prev_done_edge = edge_n;
                n_done++;
            end
            prev_busy = busy;
        end
        check("fair_done_count", 32'(n_done), 32'd6);
        check("fair_grant_count", 32'(n_gnt), 32'd6);
        for (int i = 0; i < 6; i++) check("fair_gnt_order", 32'(gnts[i]), 32'(i % 2));
        check("fair_idle_cycles", 32'(idle_steps), 32'd5);
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();

        // Abort: reset lands on the fourth ADD cycle.
        rst = 1'b1; step(); rst = 1'b0;
        req0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF;
        step();
        req0 = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        spurious = 1'b0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            step();
            if (done0 || done1) spurious = 1'b1;
        end
        check("abort_no_done", 32'(spurious), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);

        // Directed operand table, starting with the post-abort request.
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Random traffic, including mid-operation operand changes and rare resets.
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 63) == 0);
            req0 = $urandom_range(0, 1) == 1;
            req1 = $urandom_range(0, 2) != 0;
            a0 = WIDTH'($urandom); b0 = WIDTH'($urandom);
            a1 = WIDTH'($urandom); b1 = WIDTH'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
